stream_demux12: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_slot.sv | 35 +++
 rtl/stream_demux12.sv | 135 +++++++++++++
 tb/tb_stream_demux12.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types for the 1-to-2 packet stream demultiplexer.
// Holds the routing FSM encoding and a select-validity helper.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ROUTE0 = 2'b01,
    ROUTE1 = 2'b10,
    DROP   = 2'b11
  } state_t;

  // Case equality so an X/Z select is recognised as malformed in 4-state sims.
  function automatic logic sel_known(input logic s);
    return (s === 1'b0) || (s === 1'b1);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry registered output slot for a single demux branch.
// Loads a beat on load, drains on valid && ready; accept tells the router it can take a beat.
module stream_demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         din_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         last,
  output logic         accept
);

  assign accept = !valid || ready;

  // A load wins over a drain at the same edge so back-to-back beats keep valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
      last  <= din_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux12.sv
// 1-to-2 packet stream demultiplexer: whole packets steered by SD on their first beat.
// Per-branch delivered-packet counters and an error pulse for packets with a malformed select.
module stream_demux12
  import stream_demux_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          CK,
  input  logic          CD,
  input  logic [W-1:0]  D,
  input  logic          DV,
  input  logic          DL,
  output logic          DR,
  input  logic          SD,
  output logic [W-1:0]  Z0,
  output logic [W-1:0]  Z1,
  output logic          Z0V,
  output logic          Z1V,
  output logic          Z0L,
  output logic          Z1L,
  input  logic          Z0R,
  input  logic          Z1R,
  output logic [CW-1:0] PKT0,
  output logic [CW-1:0] PKT1,
  output logic          ERR
);

  state_t state, state_next;
  logic   sel_bad;
  logic   acc0, acc1;
  logic   load0, load1;
  logic   err_next;

  assign sel_bad = !sel_known(SD);

  always_ff @(posedge CK) begin
    if (CD) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DR never looks at DV or D, so no combinational path runs from the data side.
  always_comb begin
    state_next = state;
    DR         = 1'b0;
    load0      = 1'b0;
    load1      = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_bad) begin
          DR = 1'b1;
          if (DV) begin
            err_next = 1'b1;
            if (!DL) state_next = DROP;
          end
        end else if (SD) begin
          DR = acc1;
          if (DV && acc1) begin
            load1 = 1'b1;
            if (!DL) state_next = ROUTE1;
          end
        end else begin
          DR = acc0;
          if (DV && acc0) begin
            load0 = 1'b1;
            if (!DL) state_next = ROUTE0;
          end
        end
      end
      ROUTE0: begin
        DR = acc0;
        if (DV && acc0) begin
          load0 = 1'b1;
          if (DL) state_next = IDLE;
        end
      end
      ROUTE1: begin
        DR = acc1;
        if (DV && acc1) begin
          load1 = 1'b1;
          if (DL) state_next = IDLE;
        end
      end
      DROP: begin
        DR = 1'b1;
        if (DV && DL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  stream_demux_slot #(.W(W)) u_slot0 (
    .clk      (CK),
    .rst      (CD),
    .load     (load0),
    .din      (D),
    .din_last (DL),
    .ready    (Z0R),
    .valid    (Z0V),
    .dout     (Z0),
    .last     (Z0L),
    .accept   (acc0)
  );

  stream_demux_slot #(.W(W)) u_slot1 (
    .clk      (CK),
    .rst      (CD),
    .load     (load1),
    .din      (D),
    .din_last (DL),
    .ready    (Z1R),
    .valid    (Z1V),
    .dout     (Z1),
    .last     (Z1L),
    .accept   (acc1)
  );

  // A packet counts as delivered when its last beat leaves the slot, not when it enters.
  always_ff @(posedge CK) begin
    if (CD) begin
      PKT0 <= '0;
      PKT1 <= '0;
      ERR  <= 1'b0;
    end else begin
      ERR <= err_next;
      if (Z0V && Z0R && Z0L) PKT0 <= PKT0 + CW'(1);
      if (Z1V && Z1R && Z1L) PKT1 <= PKT1 + CW'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux12.sv
// Directed bench for stream_demux12: stimulus pushes expected beats into per-branch queues,
// a negedge monitor pops and compares whenever a branch handshake occurs.
module tb_stream_demux12;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          CK = 1'b0;
  logic          CD = 1'b1;
  logic [W-1:0]  D = '0;
  logic          DV = 1'b0;
  logic          DL = 1'b0;
  logic          DR;
  logic          SD = 1'b0;
  logic [W-1:0]  Z0, Z1;
  logic          Z0V, Z1V, Z0L, Z1L;
  logic          Z0R = 1'b1;
  logic          Z1R = 1'b1;
  logic [CW-1:0] PKT0, PKT1;
  logic          ERR;

  logic [W-1:0]  Dw = '0;
  logic          DVw = 1'b0;
  logic          DLw = 1'b1;
  logic          DRw;
  logic          SDw = 1'b0;
  logic [W-1:0]  Z0w, Z1w;
  logic          Z0Vw, Z1Vw, Z0Lw, Z1Lw;
  logic          Z0Rw = 1'b1;
  logic          Z1Rw = 1'b1;
  logic [3:0]    PKT0w, PKT1w;
  logic          ERRw;

  always #5 CK = ~CK;

  stream_demux12 #(.W(W), .CW(CW)) dut (
    .CK(CK), .CD(CD), .D(D), .DV(DV), .DL(DL), .DR(DR), .SD(SD),
    .Z0(Z0), .Z1(Z1), .Z0V(Z0V), .Z1V(Z1V), .Z0L(Z0L), .Z1L(Z1L),
    .Z0R(Z0R), .Z1R(Z1R), .PKT0(PKT0), .PKT1(PKT1), .ERR(ERR)
  );

  // Narrow-counter instance so the counter wrap is reached in a handful of packets.
  stream_demux12 #(.W(W), .CW(4)) dutw (
    .CK(CK), .CD(CD), .D(Dw), .DV(DVw), .DL(DLw), .DR(DRw), .SD(SDw),
    .Z0(Z0w), .Z1(Z1w), .Z0V(Z0Vw), .Z1V(Z1Vw), .Z0L(Z0Lw), .Z1L(Z1Lw),
    .Z0R(Z0Rw), .Z1R(Z1Rw), .PKT0(PKT0w), .PKT1(PKT1w), .ERR(ERRw)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t exp0[$];
  beat_t exp1[$];
  beat_t mb0, mb1;
  int    checks = 0;
  int    errors = 0;
  logic  xprobe;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic l, input logic s);
    D  = d;
    DL = l;
    SD = s;
    DV = 1'b1;
  endtask

  // br: 0/1 = expected branch, 2 = beat expected to be discarded.
  task automatic waitXfer(input int br, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge CK);
      if (DR) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL xfer timeout: DR stayed 0 for %0d cycles, expected 1", waited);
      DV = 1'b0;
    end else if (br == 0) begin
      exp0.push_back('{D, DL});
    end else if (br == 1) begin
      exp1.push_back('{D, DL});
    end
    @(posedge CK);
    #1;
  endtask

  task automatic sendBeat(input logic [W-1:0] d, input logic l, input logic s, input int br);
    int w;
    applyStimulus(d, l, s);
    waitXfer(br, w);
    checkOutput("beat stall cycles", 32'(w), 32'd0);
  endtask

  task automatic settle();
    DV = 1'b0;
    repeat (3) @(posedge CK);
    @(negedge CK);
  endtask

  task automatic realign();
    @(posedge CK);
    #1;
  endtask

  always @(negedge CK) begin
    if (!CD) begin
      if (Z0V && Z0R) begin
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL z0 unexpected beat: got 0x%0h, expected none", Z0);
        end else begin
          mb0 = exp0.pop_front();
          checkOutput("z0 data", 32'(Z0), 32'(mb0.d));
          checkOutput("z0 last", 32'(Z0L), 32'(mb0.l));
        end
      end
      if (Z1V && Z1R) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL z1 unexpected beat: got 0x%0h, expected none", Z1);
        end else begin
          mb1 = exp1.pop_front();
          checkOutput("z1 data", 32'(Z1), 32'(mb1.d));
          checkOutput("z1 last", 32'(Z1L), 32'(mb1.l));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int stalls;

    repeat (2) @(posedge CK);
    #1;
    CD = 1'b0;
    @(negedge CK);
    checkOutput("reset z0v", 32'(Z0V), 32'd0);
    checkOutput("reset z1v", 32'(Z1V), 32'd0);
    checkOutput("reset z0", 32'(Z0), 32'd0);
    checkOutput("reset z1", 32'(Z1), 32'd0);
    checkOutput("reset z0l", 32'(Z0L), 32'd0);
    checkOutput("reset z1l", 32'(Z1L), 32'd0);
    checkOutput("reset pkt0", 32'(PKT0), 32'd0);
    checkOutput("reset pkt1", 32'(PKT1), 32'd0);
    checkOutput("reset err", 32'(ERR), 32'd0);
    checkOutput("reset dr", 32'(DR), 32'd1);
    realign();

    // 3-beat packet to branch 1
    sendBeat(8'h11, 1'b0, 1'b1, 1);
    sendBeat(8'h22, 1'b0, 1'b1, 1);
    sendBeat(8'h33, 1'b1, 1'b1, 1);
    settle();
    checkOutput("t1 pkt1", 32'(PKT1), 32'd1);
    checkOutput("t1 pkt0", 32'(PKT0), 32'd0);
    checkOutput("t1 z0v", 32'(Z0V), 32'd0);
    realign();

    // SD toggles mid-packet; whole packet stays on branch 1
    sendBeat(8'h44, 1'b0, 1'b1, 1);
    sendBeat(8'h55, 1'b0, 1'b0, 1);
    sendBeat(8'h66, 1'b1, 1'b0, 1);
    settle();
    checkOutput("t2 pkt1", 32'(PKT1), 32'd2);
    checkOutput("t2 pkt0", 32'(PKT0), 32'd0);
    realign();

    // back-to-back single-beat packets to different branches
    sendBeat(8'hA0, 1'b1, 1'b0, 0);
    sendBeat(8'hB1, 1'b1, 1'b1, 1);
    settle();
    checkOutput("t3 pkt0", 32'(PKT0), 32'd1);
    checkOutput("t3 pkt1", 32'(PKT1), 32'd3);
    realign();

    // backpressure on branch 0
    Z0R = 1'b0;
    sendBeat(8'h55, 1'b1, 1'b0, 0);
    applyStimulus(8'h66, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge CK);
      checkOutput("t4 dr held", 32'(DR), 32'd0);
      checkOutput("t4 z0 held", 32'(Z0), 32'h55);
      checkOutput("t4 z0v held", 32'(Z0V), 32'd1);
    end
    realign();
    Z0R = 1'b1;
    waitXfer(0, w);
    checkOutput("t4 release stall", 32'(w), 32'd0);
    sendBeat(8'h77, 1'b1, 1'b0, 0);
    settle();
    checkOutput("t4 pkt0", 32'(PKT0), 32'd3);
    realign();

    // malformed select only observable on a 4-state simulator
    xprobe = 1'bx;
    if ($isunknown(xprobe)) begin
      applyStimulus(8'hC0, 1'b0, 1'bx);
      waitXfer(2, w);
      checkOutput("t5 drop stall", 32'(w), 32'd0);
      checkOutput("t5 err pulse", 32'(ERR), 32'd1);
      sendBeat(8'hC1, 1'b1, 1'b0, 2);
      checkOutput("t5 err cleared", 32'(ERR), 32'd0);
      checkOutput("t5 z0v", 32'(Z0V), 32'd0);
      checkOutput("t5 z1v", 32'(Z1V), 32'd0);
    end else begin
      $display("[TB] note: 2-state simulator, X-select drop case not exercised");
    end
    sendBeat(8'hD0, 1'b1, 1'b0, 0);
    settle();
    checkOutput("t5 pkt0", 32'(PKT0), 32'd4);
    checkOutput("t5 pkt1", 32'(PKT1), 32'd3);
    checkOutput("t5 err idle", 32'(ERR), 32'd0);
    realign();

    // reset mid-packet, then next beat must be a first beat
    Z1R = 1'b0;
    sendBeat(8'hE0, 1'b0, 1'b1, 1);
    DV = 1'b0;
    CD = 1'b1;
    realign();
    CD = 1'b0;
    exp0.delete();
    exp1.delete();
    @(negedge CK);
    checkOutput("t6 z0v", 32'(Z0V), 32'd0);
    checkOutput("t6 z1v", 32'(Z1V), 32'd0);
    checkOutput("t6 pkt0", 32'(PKT0), 32'd0);
    checkOutput("t6 pkt1", 32'(PKT1), 32'd0);
    checkOutput("t6 err", 32'(ERR), 32'd0);
    realign();
    Z1R = 1'b1;
    sendBeat(8'hF0, 1'b1, 1'b0, 0);
    settle();
    checkOutput("t6 pkt0 after", 32'(PKT0), 32'd1);
    checkOutput("t6 pkt1 after", 32'(PKT1), 32'd0);
    realign();

    // counter wrap on the 4-bit instance
    stalls = 0;
    for (int i = 0; i < 15; i++) begin
      Dw  = 8'(i);
      DVw = 1'b1;
      @(negedge CK);
      if (!DRw) stalls++;
      realign();
    end
    DVw = 1'b0;
    repeat (3) @(posedge CK);
    @(negedge CK);
    checkOutput("wrap stalls", 32'(stalls), 32'd0);
    checkOutput("wrap pkt0 max", 32'(PKT0w), 32'hF);
    realign();
    Dw  = 8'hEE;
    DVw = 1'b1;
    realign();
    DVw = 1'b0;
    repeat (3) @(posedge CK);
    @(negedge CK);
    checkOutput("wrap pkt0 zero", 32'(PKT0w), 32'd0);
    checkOutput("wrap z0 data", 32'(Z0w), 32'hEE);
    checkOutput("wrap z0 last", 32'(Z0Lw), 32'd1);
    checkOutput("wrap z0v", 32'(Z0Vw), 32'd0);
    checkOutput("wrap z1v", 32'(Z1Vw), 32'd0);
    checkOutput("wrap z1", 32'(Z1w), 32'd0);
    checkOutput("wrap z1l", 32'(Z1Lw), 32'd0);
    checkOutput("wrap pkt1", 32'(PKT1w), 32'd0);
    checkOutput("wrap err", 32'(ERRw), 32'd0);

    checkOutput("sb0 drained", 32'(exp0.size()), 32'd0);
    checkOutput("sb1 drained", 32'(exp1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
